// File: rtl/tcdm_stride_reader_if.sv
// Bus bundle for tcdm_stride_reader: the TCDM request/response channel
// toward memory and the valid/ready stream toward the datapath.
//
// Handshake semantics (both channels): a transfer happens on a rising edge
// where the producer's valid/req and the consumer's ready/gnt are both high.
// A producer never withdraws or changes a pending transfer while it waits.
// The one exception is tcdm_req_o, which may fall when issue credit runs out.
interface tcdm_stride_reader_if;
    logic        tcdm_req_o;
    logic        tcdm_gnt_i;
    logic [31:0] tcdm_add_o;
    logic        tcdm_wen_o;
    logic [3:0]  tcdm_be_o;
    logic [31:0] tcdm_data_o;
    logic [31:0] tcdm_r_data_i;
    logic        tcdm_r_valid_i;
    logic [31:0] stream_data_o;
    logic        stream_valid_o;
    logic        stream_ready_i;

    // Reader side.
    modport master (
        output tcdm_req_o, tcdm_add_o, tcdm_wen_o, tcdm_be_o, tcdm_data_o,
        input  tcdm_gnt_i, tcdm_r_data_i, tcdm_r_valid_i,
        output stream_data_o, stream_valid_o,
        input  stream_ready_i
    );

    // Memory and stream-consumer side.
    modport slave (
        input  tcdm_req_o, tcdm_add_o, tcdm_wen_o, tcdm_be_o, tcdm_data_o,
        output tcdm_gnt_i, tcdm_r_data_i, tcdm_r_valid_i,
        input  stream_data_o, stream_valid_o,
        output stream_ready_i
    );
endinterface

// File: rtl/tcdm_stride_reader.sv
// Strided TCDM word reader. Walks base + k*stride, issues one read per word,
// buffers responses in a small FWFT FIFO and streams them out. Issue is
// credit-limited so outstanding + buffered words never exceed FIFO_DEPTH.
module tcdm_stride_reader #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned LEN_W      = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  start_i,
    input  logic [31:0]           base_addr_i,
    input  logic [31:0]           stride_i,
    input  logic [LEN_W-1:0]      len_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  err_o,
    output logic [1:0]            dbg_state_o,
    tcdm_stride_reader_if.master  bus
);
    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [CW:0] DEPTH_C = FIFO_DEPTH[CW:0];

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [31:0]       addr_q, stride_q;
    logic [LEN_W-1:0]  remaining_q, len_q, popped_q;
    logic [CW-1:0]     outstanding_q, fifo_cnt_q;
    logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [31:0]       fifo_mem_q [FIFO_DEPTH];
    logic              done_q, err_q;

    logic              credit_ok, accept, spurious, push, pop;
    logic              launch, launch_empty, finish;
    logic [CW:0]       credit_sum;
    logic [CW-1:0]     fifo_cnt_next;
    logic [LEN_W-1:0]  popped_next;

    // Credit is computed from registered counts only, so stream_ready_i
    // never reaches tcdm_req_o combinationally.
    assign credit_sum    = {1'b0, fifo_cnt_q} + {1'b0, outstanding_q};
    assign credit_ok     = credit_sum < DEPTH_C;

    assign bus.tcdm_req_o  = (state_q == ISSUE) && credit_ok;
    assign bus.tcdm_add_o  = addr_q;
    assign bus.tcdm_wen_o  = 1'b1;
    assign bus.tcdm_be_o   = 4'hF;
    assign bus.tcdm_data_o = 32'h0;

    assign accept   = bus.tcdm_req_o && bus.tcdm_gnt_i;
    // A response with nothing outstanding has no slot reserved: flag and drop.
    assign spurious = bus.tcdm_r_valid_i && (outstanding_q == '0);
    assign push     = bus.tcdm_r_valid_i && !spurious;

    assign bus.stream_valid_o = (fifo_cnt_q != '0);
    assign bus.stream_data_o  = fifo_mem_q[rd_ptr_q];
    assign pop                = bus.stream_valid_o && bus.stream_ready_i;

    assign launch       = (state_q == IDLE) && start_i && (len_i != '0);
    assign launch_empty = (state_q == IDLE) && start_i && (len_i == '0);

    assign fifo_cnt_next = fifo_cnt_q + CW'(push) - CW'(pop);
    assign popped_next   = popped_q + LEN_W'(pop);
    // Leave DRAIN on the edge of the final pop so done/idle appear right after.
    assign finish = (state_q == DRAIN) && (outstanding_q == '0) &&
                    (fifo_cnt_next == '0) && (popped_next == len_q);

    assign busy_o      = (state_q != IDLE);
    assign done_o      = done_q;
    assign err_o       = err_q;
    assign dbg_state_o = state_q;

    // Next-state logic for the issue/drain sequencer.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (launch) state_d = ISSUE;
            ISSUE:   if (accept && (remaining_q == LEN_W'(1))) state_d = DRAIN;
            DRAIN:   if (finish) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State register plus job parameters, address walk and word counters.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            stride_q    <= '0;
            remaining_q <= '0;
            len_q       <= '0;
            popped_q    <= '0;
        end else begin
            state_q <= state_d;
            if (pop) popped_q <= popped_next;
            if (launch) begin
                addr_q      <= base_addr_i;
                stride_q    <= stride_i;
                remaining_q <= len_i;
                len_q       <= len_i;
                popped_q    <= '0;
            end else if (accept) begin
                addr_q      <= addr_q + stride_q;
                remaining_q <= remaining_q - LEN_W'(1);
            end
        end
    end

    // Outstanding-request count and the response FIFO.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            outstanding_q <= '0;
            fifo_cnt_q    <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) fifo_mem_q[i] <= '0;
        end else begin
            outstanding_q <= outstanding_q + CW'(accept) - CW'(push);
            fifo_cnt_q    <= fifo_cnt_next;
            if (push) begin
                fifo_mem_q[wr_ptr_q] <= bus.tcdm_r_data_i;
                wr_ptr_q             <= wr_ptr_q + AW'(1);
            end
            if (pop) rd_ptr_q <= rd_ptr_q + AW'(1);
        end
    end

    // Done pulse and sticky spurious-response flag.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            done_q <= finish || launch_empty;
            if (launch || launch_empty) err_q <= 1'b0;
            else if (spurious)          err_q <= 1'b1;
        end
    end
endmodule

// File: tb/tb_tcdm_stride_reader.sv
// Bench for tcdm_stride_reader: a latency-configurable memory responder and
// a stream sink run on the falling edge; directed and random jobs are
// checked against addresses and data computed from base + k*stride.
module tb_tcdm_stride_reader;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned LEN_W = 16;

    // Clock and reset
    logic             clk_i = 1'b0;
    logic             rst_ni = 1'b0;
    logic             start_i = 1'b0;
    logic [31:0]      base_addr_i = '0;
    logic [31:0]      stride_i = '0;
    logic [LEN_W-1:0] len_i = '0;
    logic             busy_o, done_o, err_o;
    logic [1:0]       dbg_state_o;

    always #5 clk_i = ~clk_i;

    tcdm_stride_reader_if bus ();

    tcdm_stride_reader #(.FIFO_DEPTH(DEPTH), .LEN_W(LEN_W)) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .start_i     (start_i),
        .base_addr_i (base_addr_i),
        .stride_i    (stride_i),
        .len_i       (len_i),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .err_o       (err_o),
        .dbg_state_o (dbg_state_o),
        .bus         (bus)
    );

    // Bench configuration (written by the stimulus block only)
    int gnt_mode = 0;    // 0: always, 1: every third cycle, 2: random
    int ready_mode = 0;  // 0: always, 1: random, 2: never
    int lat = 1;
    int spur_req = 0;

    // Model state (written by the responder/sink block only)
    int          cyc = 0;
    int          spur_ack = 0;
    int          pend_due[$];
    logic [31:0] pend_data[$];
    logic [31:0] acc_q[$];
    logic [31:0] got_q[$];
    int          acc_cnt = 0, pop_cnt = 0, job_len = 0;
    int          last_pop_cyc = 0, first_pop_cyc = 0, start_cyc = 0;
    int          stall_err = 0, drop_err = 0;
    bit          prev_stall = 0;
    logic [31:0] prev_addr = '0;

    int n_checks = 0, n_pass = 0, n_fail = 0;

    function automatic logic [31:0] data_of(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0000_00A0;
    endfunction

    // Memory responder, stream sink and protocol monitors
    always @(negedge clk_i) begin
        cyc = cyc + 1;
        if (!rst_ni) begin
            pend_due.delete();
            pend_data.delete();
            bus.tcdm_gnt_i     = 1'b0;
            bus.tcdm_r_valid_i = 1'b0;
            bus.tcdm_r_data_i  = '0;
            bus.stream_ready_i = 1'b0;
            prev_stall = 0;
        end else begin
            if (start_i && !busy_o) begin
                acc_q.delete();
                got_q.delete();
                acc_cnt = 0;
                pop_cnt = 0;
                job_len = int'(len_i);
                start_cyc = cyc;
                prev_stall = 0;
            end
            if (prev_stall && bus.tcdm_req_o && bus.tcdm_add_o !== prev_addr) stall_err++;
            if (busy_o && acc_cnt < job_len && !bus.tcdm_req_o && (acc_cnt - pop_cnt) != int'(DEPTH))
                drop_err++;
            case (ready_mode)
                0:       bus.stream_ready_i = 1'b1;
                1:       bus.stream_ready_i = 1'($urandom_range(0, 1));
                default: bus.stream_ready_i = 1'b0;
            endcase
            if (bus.stream_valid_o && bus.stream_ready_i) begin
                if (got_q.size() == 0) first_pop_cyc = cyc;
                got_q.push_back(bus.stream_data_o);
                pop_cnt++;
                last_pop_cyc = cyc;
            end
            bus.tcdm_r_valid_i = 1'b0;
            if (spur_req != spur_ack) begin
                spur_ack++;
                bus.tcdm_r_valid_i = 1'b1;
                bus.tcdm_r_data_i  = 32'hBAD0_0BAD;
            end else if (pend_due.size() > 0 && pend_due[0] <= cyc + 1) begin
                void'(pend_due.pop_front());
                bus.tcdm_r_valid_i = 1'b1;
                bus.tcdm_r_data_i  = pend_data.pop_front();
            end
            case (gnt_mode)
                0:       bus.tcdm_gnt_i = 1'b1;
                1:       bus.tcdm_gnt_i = (cyc % 3 == 0);
                default: bus.tcdm_gnt_i = 1'($urandom_range(0, 1));
            endcase
            if (bus.tcdm_req_o && bus.tcdm_gnt_i) begin
                acc_q.push_back(bus.tcdm_add_o);
                acc_cnt++;
                pend_due.push_back(cyc + 1 + lat);
                pend_data.push_back(data_of(bus.tcdm_add_o));
                prev_stall = 0;
            end else begin
                prev_stall = bus.tcdm_req_o;
                prev_addr  = bus.tcdm_add_o;
            end
        end
    end

    // Scoreboard comparison
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk_i);
        #1;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_req"},   32'(bus.tcdm_req_o), 0);
        chk({tag, "_add"},   bus.tcdm_add_o, 0);
        chk({tag, "_valid"}, 32'(bus.stream_valid_o), 0);
        chk({tag, "_data"},  bus.stream_data_o, 0);
        chk({tag, "_busy"},  32'(busy_o), 0);
        chk({tag, "_done"},  32'(done_o), 0);
        chk({tag, "_err"},   32'(err_o), 0);
    endtask

    // Driver: launch a job and check the first busy cycle
    logic [31:0] j_base, j_stride;
    int          j_len;

    task automatic start_job(input logic [31:0] base, input logic [31:0] stride,
                             input int len, input int gm, input int rm, input int l);
        @(posedge clk_i); #1;
        gnt_mode = gm; ready_mode = rm; lat = l;
        base_addr_i = base; stride_i = stride; len_i = LEN_W'(len); start_i = 1'b1;
        @(posedge clk_i); #1;
        start_i = 1'b0;
        tick();
        chk("busy_after_start", 32'(busy_o), 1);
        chk("req_after_start", 32'(bus.tcdm_req_o), 1);
        chk("err_cleared_by_start", 32'(err_o), 0);
        j_base = base; j_stride = stride; j_len = len;
    endtask

    // Wait for done and compare the job against the reference sequence
    task automatic finish_job(input int budget, input bit check_lat);
        int dcyc;
        dcyc = -1;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (done_o) begin
                dcyc = cyc;
                break;
            end
        end
        chk("done_seen", 32'(dcyc >= 0), 1);
        chk("busy_low_at_done", 32'(busy_o), 0);
        chk("done_after_last_pop", 32'(dcyc), 32'(last_pop_cyc + 1));
        if (check_lat) chk("first_data_latency", 32'(first_pop_cyc - start_cyc), 3);
        chk("accept_count", 32'(acc_q.size()), 32'(j_len));
        chk("pop_count", 32'(got_q.size()), 32'(j_len));
        for (int i = 0; i < j_len && i < acc_q.size(); i++)
            chk("addr", acc_q[i], j_base + 32'(i) * j_stride);
        for (int i = 0; i < j_len && i < got_q.size(); i++)
            chk("data", got_q[i], data_of(j_base + 32'(i) * j_stride));
        chk("stall_addr_stable", 32'(stall_err), 0);
        chk("req_drop_only_on_credit", 32'(drop_err), 0);
        chk("err_clear_after_job", 32'(err_o), 0);
        tick();
        chk("done_single_pulse", 32'(done_o), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        logic [31:0] rb, rs;

        // Reset state
        rst_ni = 1'b0;
        repeat (3) tick();
        chk_reset_outputs("reset");
        @(posedge clk_i); #1;
        rst_ni = 1'b1;
        tick();

        // Basic run: contiguous words, memory always grants
        start_job(32'h100, 32'h4, 4, 0, 0, 1);
        finish_job(200, 1'b1);

        // Stalling memory, plus a start pulse while busy that must be ignored
        start_job(32'h0, 32'h8, 6, 1, 0, 2);
        repeat (4) tick();
        @(posedge clk_i); #1;
        base_addr_i = 32'h5000; len_i = LEN_W'(1); start_i = 1'b1;
        @(posedge clk_i); #1;
        start_i = 1'b0;
        finish_job(300, 1'b0);
        repeat (3) tick();
        chk("no_restart_after_ignored_start", 32'(busy_o), 0);

        // Negative stride wraps through zero
        start_job(32'h4, 32'hFFFF_FFFC, 3, 0, 0, 1);
        finish_job(200, 1'b0);

        // Backpressure: credit caps issue at the FIFO depth
        start_job(32'h40, 32'h4, 10, 0, 2, 1);
        repeat (20) tick();
        chk("bp_accepts_capped", 32'(acc_q.size()), DEPTH);
        chk("bp_req_low", 32'(bus.tcdm_req_o), 0);
        chk("bp_fifo_valid", 32'(bus.stream_valid_o), 1);
        @(posedge clk_i); #1;
        ready_mode = 0;
        finish_job(300, 1'b0);

        // Zero-length start: done next cycle, never busy, no request
        @(posedge clk_i); #1;
        len_i = '0; start_i = 1'b1;
        @(posedge clk_i); #1;
        start_i = 1'b0;
        tick();
        chk("len0_done", 32'(done_o), 1);
        chk("len0_busy", 32'(busy_o), 0);
        chk("len0_req", 32'(bus.tcdm_req_o), 0);
        tick();
        chk("len0_done_single", 32'(done_o), 0);

        // Spurious response while idle
        @(posedge clk_i); #1;
        spur_req = spur_req + 1;
        repeat (3) tick();
        chk("spurious_err", 32'(err_o), 1);
        chk("spurious_fifo_empty", 32'(bus.stream_valid_o), 0);
        start_job(32'h800, 32'hC, 3, 2, 1, 1);
        finish_job(300, 1'b0);

        // Asynchronous reset in the middle of a job
        start_job(32'h2000, 32'h4, 5, 0, 0, 1);
        k = 0;
        while (acc_q.size() < 2 && k < 50) begin
            tick();
            k++;
        end
        chk("two_accepts_before_reset", 32'(acc_q.size()), 2);
        @(posedge clk_i); #2;
        rst_ni = 1'b0;
        #1;
        chk_reset_outputs("midrun_reset");
        repeat (2) tick();
        @(posedge clk_i); #1;
        rst_ni = 1'b1;
        tick();
        start_job(32'h3000, 32'h10, 5, 2, 1, 2);
        finish_job(400, 1'b0);

        // Random jobs: random base/stride/length, grant, backpressure, latency
        for (int j = 0; j < 6; j++) begin
            rb = $urandom;
            if ($urandom_range(0, 1) == 0) rs = 32'($urandom_range(0, 8)) << 2;
            else                           rs = $urandom;
            start_job(rb, rs, int'($urandom_range(1, 12)), 2, 1, int'($urandom_range(1, 3)));
            finish_job(600, 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
